cmos_vector_sequencer: RTL

CMOS_VECTOR_SEQUENCER -- requirements
Module: cmos_vector_sequencer

---
 rtl/cmos_vector_sequencer_if.sv | 27 ++
 rtl/cmos_vector_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/cmos_vector_sequencer_if.sv
// Signal bundle between the vector sequencer and its test controller / gate under test.
// The slave side is the sequencer; the master side drives run control and the gate output Y.
interface cmos_vector_sequencer_if;
  logic       start;
  logic       abort;
  logic       Y;
  logic       A;
  logic       B;
  logic       C;
  logic       D;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] err_cnt;
  logic       fail_vld;
  logic [3:0] fail_vec;

  modport master (
    output start, abort, Y,
    input  A, B, C, D, busy, done, pass, err_cnt, fail_vld, fail_vec
  );

  modport slave (
    input  start, abort, Y,
    output A, B, C, D, busy, done, pass, err_cnt, fail_vld, fail_vec
  );
endinterface

// File: rtl/cmos_vector_sequencer.sv
// Exhaustive 16-vector tester for the gate Y = ~(D | (A & (B | C))): drives each vector,
// waits SETTLE cycles, samples Y, and records the mismatch count and the first failing vector.
module cmos_vector_sequencer #(
  parameter int SETTLE = 2
) (
  input logic                    clk,
  input logic                    rst_n,
  cmos_vector_sequencer_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

  state_t     state, state_n;
  logic [3:0] v, v_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] abcd, abcd_n;
  logic       busy, busy_n;
  logic       done, done_n;
  logic       pass, pass_n;
  logic [4:0] err_cnt, err_n;
  logic       fail_vld, fvld_n;
  logic [3:0] fail_vec, fvec_n;
  logic       miss;

  function automatic logic expected(input logic [3:0] vec);
    return ~(vec[0] | (vec[3] & (vec[2] | vec[1])));
  endfunction

  // At most 16 mismatches per run; the count saturates rather than wrapping.
  function automatic logic [4:0] sat_inc(input logic [4:0] val);
    return (val >= 5'd16) ? 5'd16 : val + 5'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      v        <= '0;
      cnt      <= '0;
      abcd     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_vld <= 1'b0;
      fail_vec <= '0;
    end else begin
      state    <= state_n;
      v        <= v_n;
      cnt      <= cnt_n;
      abcd     <= abcd_n;
      busy     <= busy_n;
      done     <= done_n;
      pass     <= pass_n;
      err_cnt  <= err_n;
      fail_vld <= fvld_n;
      fail_vec <= fvec_n;
    end
  end

  always_comb begin
    state_n = state;
    v_n     = v;
    cnt_n   = cnt;
    pass_n  = pass;
    err_n   = err_cnt;
    fvld_n  = fail_vld;
    fvec_n  = fail_vec;
    miss    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_n = ST_SETTLE;
          v_n     = '0;
          cnt_n   = '0;
          pass_n  = 1'b0;
          err_n   = '0;
          fvld_n  = 1'b0;
          fvec_n  = '0;
        end
      end
      ST_SETTLE: begin
        if (bus.abort) begin
          state_n = ST_IDLE;
          pass_n  = 1'b0;
        end else begin
          cnt_n = cnt + 4'd1;
          if (cnt == 4'(SETTLE - 1)) state_n = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        if (bus.abort) begin
          state_n = ST_IDLE;
          pass_n  = 1'b0;
        end else begin
          // X/Z on Y must also register as a failure, hence the case inequality.
          miss = (bus.Y !== expected(v));
          if (miss) begin
            err_n = sat_inc(err_cnt);
            if (!fail_vld) begin
              fvld_n = 1'b1;
              fvec_n = v;
            end
          end
          if (v == 4'd15) begin
            state_n = ST_DONE;
            pass_n  = (err_n == 5'd0);
          end else begin
            state_n = ST_SETTLE;
            v_n     = v + 4'd1;
            cnt_n   = '0;
          end
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    // Outputs are registered from the next state so they line up with the state they describe.
    busy_n = (state_n == ST_SETTLE) || (state_n == ST_SAMPLE);
    abcd_n = busy_n ? v_n : 4'd0;
    done_n = (state_n == ST_DONE);
  end

  assign bus.A        = abcd[3];
  assign bus.B        = abcd[2];
  assign bus.C        = abcd[1];
  assign bus.D        = abcd[0];
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.pass     = pass;
  assign bus.err_cnt  = err_cnt;
  assign bus.fail_vld = fail_vld;
  assign bus.fail_vec = fail_vec;

endmodule
